// File: rtl/id_operand_fetch_pkg.sv
// Shared definitions for the decode/operand-fetch stage.
// Holds the default geometry (data width, register count, index width),
// the field layout of the opaque decoded-control bundle, and a small helper
// used by the scoreboard to count simultaneous decrements.
package id_operand_fetch_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int REG_AW_DEF   = 4;
  localparam int CTRL_W_DEF   = 16;

  // Field layout of the 16-bit control bundle. The stage never looks inside
  // it; the struct documents what EX expects to find.
  typedef struct packed {
    logic       s;         // update flags
    logic       b;         // byte access
    logic [3:0] ex_cmd;    // ALU operation
    logic       mem_w;     // store
    logic       mem_r;     // load
    logic       wb_en;     // register write-back
    logic       imm;       // second operand is an immediate
    logic [2:0] shift_op;  // shifter operand selector
    logic [2:0] simm;      // signed immediate (short form)
  } ctrl_t;

  // Number of asserted decrement sources (0..3).
  function automatic logic [1:0] dec_count(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard.
// One saturating counter per architectural register tracks writes that have
// issued but not yet retired (written back, killed or flushed).
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   q_src, q_src_used     source indices / use flags of the instruction in ID
//   q_dest, q_wb_en       destination of the instruction in ID
//   inc_en, inc_dest      an instruction with a write issues this cycle
//   wb_en, wb_dest        write-back retires one pending write
//   kill_en, kill_dest    squashed instruction retires one pending write
//   drop_en, drop_dest    flushed ID/EX instruction retires one pending write
//   hazard                the instruction in ID must not issue this cycle
//   sb_err                sticky: a counter was decremented below zero
module id_scoreboard
  import id_operand_fetch_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_RD   = 2,
  parameter int CNT_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*REG_AW-1:0] q_src,
  input  logic [NUM_RD-1:0]        q_src_used,
  input  logic [REG_AW-1:0]        q_dest,
  input  logic                     q_wb_en,
  input  logic                     inc_en,
  input  logic [REG_AW-1:0]        inc_dest,
  input  logic                     wb_en,
  input  logic [REG_AW-1:0]        wb_dest,
  input  logic                     kill_en,
  input  logic [REG_AW-1:0]        kill_dest,
  input  logic                     drop_en,
  input  logic [REG_AW-1:0]        drop_dest,
  output logic                     hazard,
  output logic                     sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]          cnt_reg [NUM_REGS];
  logic [NUM_REGS*CNT_W-1:0] cnt_next;
  logic [NUM_REGS-1:0]       err_hit;
  logic [NUM_RD-1:0]         src_block;
  logic                      dest_block;
  logic                      sb_err_reg;

  genvar gi;

  // A single pending write may still be satisfied by a write-back landing in
  // this very cycle (the bypass supplies the value); two or more may not.
  for (gi = 0; gi < NUM_RD; gi++) begin : g_port
    logic [REG_AW-1:0] src;
    logic [CNT_W-1:0]  c;
    logic              wb_hit;
    assign src    = q_src[gi*REG_AW +: REG_AW];
    assign c      = cnt_reg[src];
    assign wb_hit = wb_en && (wb_dest == src);
    assign src_block[gi] = q_src_used[gi] &&
                           ((c > CNT_W'(1)) || ((c == CNT_W'(1)) && !wb_hit));
  end

  assign dest_block = q_wb_en && (cnt_reg[q_dest] == CNT_MAX);
  assign hazard     = (|src_block) || dest_block;

  // Per-register next count, computed two bits wider so that underflow and
  // overflow are both visible before clamping.
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
    logic             inc;
    logic [1:0]       dec;
    logic [CNT_W+1:0] sum;
    logic [CNT_W+1:0] dec_ext;
    logic [CNT_W+1:0] diff;
    assign inc = inc_en && (inc_dest == REG_AW'(gi));
    assign dec = dec_count(wb_en   && (wb_dest   == REG_AW'(gi)),
                           kill_en && (kill_dest == REG_AW'(gi)),
                           drop_en && (drop_dest == REG_AW'(gi)));
    assign sum     = {2'b00, cnt_reg[gi]} + (CNT_W+2)'(inc);
    assign dec_ext = {CNT_W'(0), dec};
    assign diff    = sum - dec_ext;
    assign err_hit[gi] = dec_ext > sum;
    assign cnt_next[gi*CNT_W +: CNT_W] =
        err_hit[gi]               ? '0 :
        (diff > {2'b00, CNT_MAX}) ? CNT_MAX :
                                    diff[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_reg[i] <= '0;
      sb_err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_reg[i] <= cnt_next[i*CNT_W +: CNT_W];
      if (|err_hit) sb_err_reg <= 1'b1;
    end
  end

  assign sb_err = sb_err_reg;

endmodule

// File: rtl/id_operand_fetch.sv
// Decode/operand-fetch stage.
// Reads NUM_RD source operands from the register file (with same-cycle
// write-back bypass), stalls on pending writes tracked by id_scoreboard and
// holds the issued instruction in the ID/EX register.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready              upstream handshake
//   in_src, in_src_used            source indices and per-port use flags
//   in_dest, in_wb_en, in_ctrl     destination, write flag, control bundle
//   out_valid/out_ready            downstream handshake
//   out_ctrl, out_dest, out_wb_en  registered instruction fields
//   out_val                        registered operand values (port k at k*DATA_W)
//   wb_en, wb_dest, wb_value       write-back port
//   kill_en, kill_dest             squash of an instruction beyond ID/EX
//   flush                          drop held instruction, block acceptance
//   sb_err                         sticky scoreboard underflow flag
module id_operand_fetch
  import id_operand_fetch_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_RD   = 2,
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int CNT_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_RD*REG_AW-1:0] in_src,
  input  logic [NUM_RD-1:0]        in_src_used,
  input  logic [REG_AW-1:0]        in_dest,
  input  logic                     in_wb_en,
  input  logic [CTRL_W-1:0]        in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [REG_AW-1:0]        out_dest,
  output logic                     out_wb_en,
  output logic [NUM_RD*DATA_W-1:0] out_val,
  input  logic                     wb_en,
  input  logic [REG_AW-1:0]        wb_dest,
  input  logic [DATA_W-1:0]        wb_value,
  input  logic                     kill_en,
  input  logic [REG_AW-1:0]        kill_dest,
  input  logic                     flush,
  output logic                     sb_err
);

  logic [DATA_W-1:0]        rf_reg [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_val;
  logic                     hazard;
  logic                     accept;
  logic                     drop_en;

  logic                     out_valid_reg;
  logic [CTRL_W-1:0]        out_ctrl_reg;
  logic [REG_AW-1:0]        out_dest_reg;
  logic                     out_wb_en_reg;
  logic [NUM_RD*DATA_W-1:0] out_val_reg;

  genvar gi;

  // Operand read with bypass from the write-back port.
  for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [REG_AW-1:0] src;
    assign src = in_src[gi*REG_AW +: REG_AW];
    assign rd_val[gi*DATA_W +: DATA_W] =
        (wb_en && (wb_dest == src)) ? wb_value : rf_reg[src];
  end

  assign in_ready = !flush && !hazard && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  // A flushed instruction that would have written back never will, so its
  // pending write is retired here.
  assign drop_en  = flush && out_valid_reg && out_wb_en_reg;

  id_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW),
    .NUM_RD   (NUM_RD),
    .CNT_W    (CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .q_src      (in_src),
    .q_src_used (in_src_used),
    .q_dest     (in_dest),
    .q_wb_en    (in_wb_en),
    .inc_en     (accept && in_wb_en),
    .inc_dest   (in_dest),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .kill_en    (kill_en),
    .kill_dest  (kill_dest),
    .drop_en    (drop_en),
    .drop_dest  (out_dest_reg),
    .hazard     (hazard),
    .sb_err     (sb_err)
  );

  // Register file; cleared on reset so operand values are deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_reg[i] <= '0;
    end else if (wb_en) begin
      rf_reg[wb_dest] <= wb_value;
    end
  end

  // ID/EX register. Flush never coincides with an accept (in_ready is low).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_ctrl_reg  <= '0;
      out_dest_reg  <= '0;
      out_wb_en_reg <= 1'b0;
      out_val_reg   <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_ctrl_reg  <= in_ctrl;
      out_dest_reg  <= in_dest;
      out_wb_en_reg <= in_wb_en;
      out_val_reg   <= rd_val;
    end else if (flush || out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_ctrl  = out_ctrl_reg;
  assign out_dest  = out_dest_reg;
  assign out_wb_en = out_wb_en_reg;
  assign out_val   = out_val_reg;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Self-checking bench for id_operand_fetch (default parameters).
// A behavioural model (pending-write counts, register contents, held
// instruction) is stepped once per cycle; a compare process checks every DUT
// output against it on each falling edge, and directed scenarios add literal
// expectations.
module tb_id_operand_fetch;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int RD = 2;
  localparam int CW = 16;
  localparam int MAXC = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid;
  logic           in_ready;
  logic [RD*AW-1:0] in_src;
  logic [RD-1:0]  in_src_used;
  logic [AW-1:0]  in_dest;
  logic           in_wb_en;
  logic [CW-1:0]  in_ctrl;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  out_ctrl;
  logic [AW-1:0]  out_dest;
  logic           out_wb_en;
  logic [RD*DW-1:0] out_val;
  logic           wb_en;
  logic [AW-1:0]  wb_dest;
  logic [DW-1:0]  wb_value;
  logic           kill_en;
  logic [AW-1:0]  kill_dest;
  logic           flush;
  logic           sb_err;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 0;

  // Model state
  logic [DW-1:0]    m_regs [NR];
  int               m_cnt  [NR];
  bit               m_err;
  bit               m_valid;
  logic [CW-1:0]    m_ctrl;
  logic [AW-1:0]    m_dest;
  bit               m_wb;
  logic [RD*DW-1:0] m_val;

  id_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_src_used(in_src_used),
    .in_dest(in_dest), .in_wb_en(in_wb_en), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_dest(out_dest), .out_wb_en(out_wb_en), .out_val(out_val),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .kill_en(kill_en), .kill_dest(kill_dest),
    .flush(flush), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_err = 0; m_valid = 0; m_ctrl = '0; m_dest = '0; m_wb = 0; m_val = '0;
  endtask

  // An instruction may issue when every used source has no outstanding write,
  // or exactly one that is being written back right now; its destination
  // must have room for another in-flight write; EX must be able to take it.
  function automatic bit model_ready();
    bit blocked = 0;
    for (int k = 0; k < RD; k++) begin
      int s;
      s = int'(in_src[k*AW +: AW]);
      if (in_src_used[k]) begin
        if (m_cnt[s] >= 2) blocked = 1;
        else if (m_cnt[s] == 1 && !(wb_en && int'(wb_dest) == s)) blocked = 1;
      end
    end
    if (in_wb_en && m_cnt[in_dest] == MAXC) blocked = 1;
    return !flush && !blocked && (!m_valid || out_ready);
  endfunction

  // Advance the model by one clock edge using the inputs of this cycle.
  task automatic model_step();
    bit acc, drop;
    logic [DW-1:0] ops [RD];
    if (rst) begin
      model_reset();
      return;
    end
    acc  = in_valid && model_ready();
    drop = flush && m_valid && m_wb;
    for (int k = 0; k < RD; k++) begin
      int s;
      s = int'(in_src[k*AW +: AW]);
      ops[k] = (wb_en && int'(wb_dest) == s) ? wb_value : m_regs[s];
    end
    for (int r = 0; r < NR; r++) begin
      int n, d;
      n = m_cnt[r] + ((acc && in_wb_en && int'(in_dest) == r) ? 1 : 0);
      d = ((wb_en && int'(wb_dest) == r) ? 1 : 0) +
          ((kill_en && int'(kill_dest) == r) ? 1 : 0) +
          ((drop && int'(m_dest) == r) ? 1 : 0);
      if (d > n) begin
        m_cnt[r] = 0;
        m_err = 1;
      end else begin
        m_cnt[r] = (n - d > MAXC) ? MAXC : n - d;
      end
    end
    if (acc) begin
      m_valid = 1;
      m_ctrl  = in_ctrl;
      m_dest  = in_dest;
      m_wb    = in_wb_en;
      for (int k = 0; k < RD; k++) m_val[k*DW +: DW] = ops[k];
      $display("issue: ctrl=%h dest=%0d wb=%0d val=%h", in_ctrl, in_dest, in_wb_en, {ops[1], ops[0]});
    end else if (flush || out_ready) begin
      m_valid = 0;
    end
    if (wb_en) m_regs[wb_dest] = wb_value;
  endtask

  // Compare process: every falling edge outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && checking) begin
        check("in_ready",  in_ready,  model_ready());
        check("out_valid", out_valid, m_valid);
        check("out_ctrl",  out_ctrl,  m_ctrl);
        check("out_dest",  out_dest,  m_dest);
        check("out_wb_en", out_wb_en, m_wb);
        check("out_val",   out_val,   m_val);
        check("sb_err",    sb_err,    m_err);
      end
    end
  end

  // One clock: model advances after the falling-edge compare, inputs for the
  // next cycle are applied 2 time units after the rising edge.
  task automatic cyc();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    in_valid = 0; in_src = '0; in_src_used = '0; in_dest = '0; in_wb_en = 0; in_ctrl = '0;
    wb_en = 0; wb_dest = '0; wb_value = '0; kill_en = 0; kill_dest = '0; flush = 0;
  endtask

  task automatic set_in(input int s0, input int s1, input logic [1:0] used,
                        input int dest, input bit wb, input logic [CW-1:0] ctrl);
    in_valid = 1;
    in_src = {AW'(s1), AW'(s0)};
    in_src_used = used;
    in_dest = AW'(dest);
    in_wb_en = wb;
    in_ctrl = ctrl;
  endtask

  task automatic do_wb(input int dest, input logic [DW-1:0] value);
    wb_en = 1; wb_dest = AW'(dest); wb_value = value;
  endtask

  initial begin
    idle();
    out_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    checking = 1;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset sb_err", sb_err, 0);
    check("reset out_val", out_val, 0);

    // Establish R1=5, R2=7 through issued writers.
    set_in(0, 0, 2'b00, 1, 1, 16'h0101); cyc();
    set_in(0, 0, 2'b00, 2, 1, 16'h0102); cyc();
    idle(); do_wb(1, 32'd5); cyc();
    idle(); do_wb(2, 32'd7); cyc();

    // Single issue reading R1, R2, writing R3.
    idle(); set_in(1, 2, 2'b11, 3, 1, 16'h0303); #1;
    check("issue ready", in_ready, 1);
    cyc();
    idle(); #1;
    check("first out_valid", out_valid, 1);
    check("first out_val", out_val, {32'd7, 32'd5});

    // Read-after-write on R3: stalls until its write-back, then bypasses.
    set_in(3, 0, 2'b01, 7, 0, 16'h0404); #1;
    check("raw stall 1", in_ready, 0);
    cyc(); #1;
    check("raw stall 2", in_ready, 0);
    cyc();
    do_wb(3, 32'h2A); #1;
    check("raw bypass ready", in_ready, 1);
    cyc();
    idle(); #1;
    check("raw bypass value", out_val[31:0], 32'h2A);
    cyc();

    // Destination limit: three writes to R4 in flight block a fourth.
    set_in(0, 0, 2'b00, 4, 1, 16'h0505); cyc(); cyc(); cyc(); #1;
    check("sat block", in_ready, 0);
    cyc();
    do_wb(4, 32'h44); #1;
    check("sat block during wb", in_ready, 0);
    cyc();
    wb_en = 0; #1;
    check("sat unblock", in_ready, 1);
    cyc();
    idle(); cyc();

    // Flush of a held writer to R6.
    out_ready = 0;
    set_in(0, 0, 2'b00, 6, 1, 16'h0606); cyc();
    set_in(0, 0, 2'b00, 8, 0, 16'h0707); flush = 1; #1;
    check("flush blocks accept", in_ready, 0);
    cyc();
    idle(); #1;
    check("flush out_valid", out_valid, 0);
    out_ready = 1;
    set_in(6, 0, 2'b01, 9, 0, 16'h0808); #1;
    check("R6 free after flush", in_ready, 1);
    cyc();
    idle();

    // Kill of a pending write to R5.
    set_in(0, 0, 2'b00, 5, 1, 16'h0909); cyc();
    set_in(5, 0, 2'b01, 10, 0, 16'h0A0A); kill_en = 1; kill_dest = 5; #1;
    check("kill same cycle", in_ready, 0);
    cyc();
    kill_en = 0; #1;
    check("kill next cycle", in_ready, 1);
    cyc();
    idle(); kill_en = 1; kill_dest = 5; cyc();
    kill_en = 0; #1;
    check("sb_err set", sb_err, 1);
    cyc(); cyc(); #1;
    check("sb_err sticky", sb_err, 1);

    // Backpressure for three cycles, then reset mid-stall.
    out_ready = 0;
    set_in(1, 2, 2'b11, 11, 0, 16'h0B0B); cyc();
    set_in(2, 1, 2'b11, 12, 0, 16'h0C0C);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp stall", in_ready, 0);
      check("bp hold dest", out_dest, 4'd11);
      check("bp hold val", out_val, {32'd7, 32'd5});
      cyc();
    end
    #1;
    rst = 1;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_ctrl", out_ctrl, 0);
    check("rst out_dest", out_dest, 0);
    check("rst out_wb_en", out_wb_en, 0);
    check("rst out_val", out_val, 0);
    check("rst sb_err", sb_err, 0);
    model_reset();
    cyc(); cyc();
    rst = 0;
    cyc(); cyc();
    idle(); out_ready = 1;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
Parametrised decode/operand-fetch stage for the ARM pipeline. It combines a multi-read-port register file with write-back bypass, a per-register pending-write scoreboard, and an ID/EX output register.
- Upstream and downstream use a valid/ready handshake.
- Instructions issue in order; an instruction stalls while any source it reads has an outstanding write.
- It sits between the IF/ID register and the EX stage, and takes write-back and kill inputs from the WB stage and the flush logic.

Parameters:
DATA_W, 32, register and data width
NUM_REGS, 16, number of architectural registers (power of 2)
REG_AW, 4, register index width, equal to log2(NUM_REGS)
NUM_RD, 2, number of source read ports (1..4)
CTRL_W, 16, width of the opaque decoded-control bundle passed through
CNT_W, 2, width of each scoreboard counter; max in-flight writes per register is 2^CNT_W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
in_src  in  NUM_RD*REG_AW  source register indices; port k occupies [k*REG_AW +: REG_AW]
in_src_used  in  NUM_RD  per-port flag: source k is actually read
in_dest  in  REG_AW  destination register
in_wb_en  in  1  instruction writes in_dest
in_ctrl  in  CTRL_W  decoded control, passed through unchanged
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX consumes the held instruction
out_ctrl  out  CTRL_W  registered control
out_dest  out  REG_AW  registered destination
out_wb_en  out  1  registered write enable
out_val  out  NUM_RD*DATA_W  registered operand values
wb_en  in  1  write-back strobe
wb_dest  in  REG_AW  write-back register
wb_value  in  DATA_W  write-back data
kill_en  in  1  an issued instruction downstream of ID/EX was squashed
kill_dest  in  REG_AW  destination of the squashed instruction
flush  in  1  drop the held instruction and block acceptance this cycle
sb_err  out  1  sticky: a decrement was applied to a counter already at 0

Behaviour:
Reset (asynchronous):
- All registers are cleared to 0 and all counters to 0.
- out_valid=0, out_ctrl=0, out_dest=0, out_wb_en=0, out_val=0, sb_err=0.
- Reset mid-operation discards all state immediately.

Register file:
- Written at the clock edge when wb_en is high.
- Reads are combinational.
- Bypass: if wb_en && wb_dest==src, the read returns wb_value in the same cycle.

Hazard, per source port k:
- Only ports with in_src_used[k]=1 participate.
- Blocked if cnt[src]>=2.
- Blocked if cnt[src]==1 and no wb_en with wb_dest==src this cycle.
- A kill of src does not unblock the port in the same cycle.

Destination limit:
- When in_wb_en=1, the instruction is blocked if cnt[in_dest]==2^CNT_W-1.

in_ready:
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- in_ready is independent of in_valid.

Accept (in_valid && in_ready), latency 1:
- At the next edge the output register loads ctrl, dest, wb_en and the bypassed operands, and out_valid=1.
- If an accept and a consume happen in the same cycle, the register reloads.
- If it is consumed with no accept, out_valid goes to 0.

flush:
- At the edge, out_valid goes to 0.
- If out_valid && out_wb_en, the held instruction counts as one decrement on out_dest.

Scoreboard update, per register r, at each edge:
- inc = (accept && in_wb_en && in_dest==r).
- dec = number of these matching r: (wb_en, wb_dest), (kill_en, kill_dest), (flush drop, out_dest).
- cnt[r] <= cnt[r] + inc - dec.
- If dec exceeds cnt[r]+inc, the counter clamps at 0 and sb_err is set.
- If the increment would exceed the maximum, the counter saturates; the destination check makes this unreachable.

Other rules:
- Simultaneous issue and write-back to the same register leaves its counter unchanged.
- Register index 0 gets no special treatment.

Decomposition:
- Shared package/header: DATA_W, REG_AW and NUM_REGS defaults, and the CTRL bundle field layout (S, B, EX_CMD, MEM_W, MEM_R, WB_EN, Imm, shifter operand, signed immediate).
- One natural sub-module, id_scoreboard: counter array, per-register inc/dec, hazard query for NUM_RD ports, and sb_err.
- The register file and the output register stay in the top module.

Test Plan:
- Reset then a single issue (src 1 and 2 used, dest 3, wb_en=1) with prior writes R1=5 and R2=7 -> out_valid one cycle later, out_val={7,5}, cnt[3]=1.
- Back-to-back RAW (issue dest 3, then an instruction reading R3) -> in_ready=0 until wb_en with wb_dest=3 and wb_value=0x2A; in that cycle in_ready=1 and the bypassed out_val is 0x2A.
- Destination saturation with CNT_W=2: three writes to R4 in flight -> a fourth writer is blocked until one write-back arrives.
- flush while holding an instruction with dest 6 and wb_en=1 -> out_valid=0, cnt[6] returns to 0, no accept in that cycle.
- kill_en with kill_dest=5 while cnt[5]=1 -> cnt[5]=0 and readers of R5 unstall the next cycle; a kill with cnt=0 -> sb_err=1, which stays set until reset.
- out_ready=0 backpressure for 3 cycles -> outputs hold steady and in_ready=0; asserting rst mid-stall -> all outputs 0 immediately.
